// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle adder/subtractor that processes CHUNK bits per clock.
// Latency: result valid N+1 cycles after the accepting cycle (N = WIDTH/CHUNK).
// Backpressure: result is held in DONE until out_ready; in_ready only in IDLE.
// Optional feature: define CHUNK_ADDER_OVF_EN to add the signed-overflow port ovf.
module chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef CHUNK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // WIDTH must be an integer multiple of CHUNK.
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  // Operand b is stored already inverted for subtraction, so the captured
  // sub flag is folded into b_q and the initial carry.
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_res;

  // Only IDLE accepts, and never while reset is held.
  assign in_ready = (state == IDLE) & rst_n;

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

  // One CHUNK-wide ripple slice, selected by the chunk index.
  assign a_chunk   = a_q[k*CHUNK +: CHUNK];
  assign b_chunk   = b_q[k*CHUNK +: CHUNK];
  assign chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

  // Control FSM plus datapath registers: capture, iterate over chunks, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            // Subtraction is a + ~b + 1, so cin is ignored when sub=1.
            carry_q <= sub | cin;
            k       <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[k*CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
          carry_q                 <= chunk_res[CHUNK];
          k                       <= k + 1'b1;
          if (k == K_LAST) begin
            cout_q      <= chunk_res[CHUNK];
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Consuming cycle returns to IDLE; the next accept is one cycle later.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHUNK_ADDER_OVF_EN
  logic msb_cin_q;

  // Capture the carry into the MSB during the last chunk; carry-in of a bit
  // is recovered as a ^ b ^ sum for that bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_cin_q <= 1'b0;
    end else if (state == RUN && k == K_LAST) begin
      msb_cin_q <= a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1];
    end
  end

  // Signed overflow: carry into MSB differs from carry out of MSB.
  assign ovf = msb_cin_q ^ cout_q;
`endif

endmodule

// File: tb/tb_chunk_adder.sv
// tb_chunk_adder: randomized and directed bench for chunk_adder (WIDTH=16, CHUNK=4).
// Expected results come from plain integer arithmetic on the operands.
// Define CHUNK_ADDER_OVF_EN to also check the ovf output.
module tb_chunk_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
`ifdef CHUNK_ADDER_OVF_EN
  logic             ovf;
`endif

  int vectors;
  int miscompares;

  chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CHUNK_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain modular arithmetic and sign rules.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                input logic mcin, input logic msub,
                                output logic [15:0] ms, output logic mco, output logic mov);
    int unsigned full;
    if (msub) begin
      ms  = ma - mb;
      mco = (ma >= mb);
      mov = (ma[15] != mb[15]) && (ms[15] != ma[15]);
    end else begin
      full = 32'(ma) + 32'(mb) + 32'(mcin);
      ms   = full[15:0];
      mco  = full[16];
      mov  = (ma[15] == mb[15]) && (ms[15] != ma[15]);
    end
  endfunction

  function automatic logic get_ovf();
`ifdef CHUNK_ADDER_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one operation and observes its result; no checking here.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                        input logic tsub, input int hold,
                        output logic [15:0] s, output logic co, output logic ov,
                        output int lat, output bit timed_out);
    int w;
    timed_out = 1'b0;
    s = '0; co = 1'b0; ov = 1'b0; lat = 0;
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      in_valid  = 1'b0;
      timed_out = 1'b1;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      timed_out = 1'b1;
      return;
    end
    s  = sum;
    co = cout;
    ov = get_ovf();
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #23;
    vectors++;
    if ({in_ready, out_valid, cout, get_ovf()} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy/vld/cout/ovf=%b required 0000",
               {in_ready, out_valid, cout, get_ovf()});
    end
    vectors++;
    if (sum !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_sum: got %h required 0000", sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [6] = '{16'h00FF, 16'hFFFF, 16'h1234, 16'h0005, 16'h7FFF, 16'h8000};
    logic [15:0] vb [6] = '{16'h0001, 16'h0001, 16'h1111, 16'h0007, 16'h0001, 16'h0001};
    logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] es [6] = '{16'h0100, 16'h0000, 16'h2346, 16'hFFFE, 16'h8000, 16'h7FFF};
    logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        eo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] s;
    logic co, ov;
    int lat;
    bit to;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vc[i], vs[i], 0, s, co, ov, lat, to);
      vectors++;
      if (to) begin
        miscompares++;
        $display("FAIL directed%0d_timeout: no handshake/result within budget", i);
        continue;
      end
      vectors++;
      if (lat !== N) begin
        miscompares++;
        $display("FAIL directed%0d_latency: got %0d edges required %0d", i, lat, N);
      end
      vectors++;
      if (s !== es[i] || co !== ec[i]) begin
        miscompares++;
        $display("FAIL directed%0d_result: got %h/%b required %h/%b", i, s, co, es[i], ec[i]);
      end
`ifdef CHUNK_ADDER_OVF_EN
      vectors++;
      if (ov !== eo[i]) begin
        miscompares++;
        $display("FAIL directed%0d_ovf: got %b required %b", i, ov, eo[i]);
      end
`else
      if (ov !== 1'b0 && eo[i] === 1'bx) miscompares++;
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a0, b0, a1, b1, s0, es;
    logic ec, eo;
    int w;
    a0 = 16'($urandom); b0 = 16'($urandom);
    a1 = 16'($urandom); b1 = 16'($urandom);
    @(negedge clk);
    a = a0; b = b0; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (!out_valid) begin
      miscompares++;
      $display("FAIL bp_timeout: out_valid got 0 required 1");
      in_valid = 1'b0;
      return;
    end
    model(a0, b0, 1'b0, 1'b0, es, ec, eo);
    s0 = sum;
    vectors++;
    if (s0 !== es || cout !== ec) begin
      miscompares++;
      $display("FAIL bp_first_result: got %h/%b required %h/%b", s0, cout, es, ec);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || sum !== s0 || cout !== ec || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got vld=%b sum=%h cout=%b rdy=%b required 1/%h/%b/0",
                 i, out_valid, sum, cout, in_ready, s0, ec);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    a = a1; b = b1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_consume: got vld=%b rdy=%b required 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_second_accept: in_ready got %b required 0", in_ready);
    end
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    model(a1, b1, 1'b0, 1'b0, es, ec, eo);
    vectors++;
    if (out_valid !== 1'b1 || sum !== es || cout !== ec) begin
      miscompares++;
      $display("FAIL bp_second_result: got vld=%b %h/%b required 1 %h/%b",
               out_valid, sum, cout, es, ec);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [15:0] na, nb, es;
    logic ec, eo;
    int lat;
    na = 16'($urandom); nb = 16'($urandom);
    @(negedge clk);
    a = 16'h0FFF; b = 16'h0FFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, cout, get_ovf()} !== 4'b0000 || sum !== 16'h0000) begin
      miscompares++;
      $display("FAIL arst_immediate: got rdy/vld/cout/ovf=%b sum=%h required 0000 0000",
               {in_ready, out_valid, cout, get_ovf()}, sum);
    end
    #17;
    vectors++;
    if ({in_ready, out_valid, sum} !== 18'h0) begin
      miscompares++;
      $display("FAIL arst_held: got rdy=%b vld=%b sum=%h required 0/0/0000",
               in_ready, out_valid, sum);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    a = na; b = nb; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_release: got rdy=%b vld=%b required 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_first_accept: in_ready got %b required 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    model(na, nb, 1'b0, 1'b1, es, ec, eo);
    vectors++;
    if (lat !== N || sum !== es || cout !== ec) begin
      miscompares++;
      $display("FAIL arst_fresh_op: got lat=%0d %h/%b required lat=%0d %h/%b",
               lat, sum, cout, N, es, ec);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, s, es;
    logic rc, rs, co, ov, ec, eo;
    int lat;
    bit to;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) ra = 16'hFFFF;
      if (i % 8 == 1) rb = ra;
      run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), s, co, ov, lat, to);
      model(ra, rb, rc, rs, es, ec, eo);
      vectors++;
      if (to || lat !== N || s !== es || co !== ec) begin
        miscompares++;
        $display("FAIL random%0d a=%h b=%h cin=%b sub=%b: got to=%b lat=%0d %h/%b required lat=%0d %h/%b",
                 i, ra, rb, rc, rs, to, lat, s, co, N, es, ec);
      end
`ifdef CHUNK_ADDER_OVF_EN
      vectors++;
      if (ov !== eo) begin
        miscompares++;
        $display("FAIL random%0d_ovf: got %b required %b", i, ov, eo);
      end
`endif
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_async_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/chunk_adder.md
CHUNK_ADDER -- requirements
Module: chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in, used for add only.
REQ-007 The block SHALL have port sub, input, 1 bit: 1 selects a - b, 0 selects a + b + cin.
REQ-008 The block SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: operand handshake.
REQ-009 The block SHALL have port sum, output, WIDTH bits, and port cout, output, 1 bit: result and carry out of the MSB.
REQ-010 The block SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: result handshake.
REQ-011 The block SHALL have port ovf, output, 1 bit, only when CHUNK_ADDER_OVF_EN is defined: two's-complement signed overflow.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 exactly when the state is IDLE and rst_n is high.
REQ-014 In IDLE, in_valid=1 SHALL capture a, b, sub and the effective carry (cin, or 1 when sub=1), clear chunk index k to 0, and move to RUN; inputs SHALL be ignored at all other times.
REQ-015 With sub=1 the captured b SHALL be bitwise inverted and the carry forced to 1; cin SHALL be ignored.
REQ-016 In RUN, each cycle SHALL add chunk k of a, chunk k of b and the carry register, write chunk k of sum, update the carry register from the chunk carry-out, and increment k.
REQ-017 After the cycle processing k = N-1, the block SHALL move to DONE; cout SHALL equal the final carry register value.
REQ-018 If the handshake occurs in cycle T, out_valid SHALL be 1 from cycle T+N+1 (CHUNK=WIDTH gives T+2).
REQ-019 In DONE, sum, cout, ovf and out_valid SHALL hold stable until out_ready=1; that cycle SHALL return the state to IDLE and clear out_valid.
REQ-020 A new operand SHALL NOT be accepted in the same cycle a result is consumed; the earliest next accept is the following cycle.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; cout for subtraction SHALL be 1 when no borrow occurs (a >= b unsigned).
REQ-022 sum SHALL be undefined to observers while out_valid=0; verification SHALL check it only when out_valid=1.

Reset
REQ-023 While rst_n=0, the state SHALL be IDLE, k SHALL be 0, and the carry register, sum, cout, ovf, out_valid and in_ready SHALL all be 0, regardless of clk.
REQ-024 Reset asserted in RUN or DONE SHALL abandon the operation with no result ever presented for it.
REQ-025 The first rising edge after rst_n deasserts SHALL be able to accept an operand.

Configuration
REQ-026 With CHUNK_ADDER_OVF_EN defined, the ovf port SHALL exist.
REQ-027 With CHUNK_ADDER_OVF_EN defined, the block SHALL register the carry into the MSB on the last RUN cycle.
REQ-028 With CHUNK_ADDER_OVF_EN defined, ovf SHALL equal that registered MSB carry-in XOR cout and SHALL be valid with out_valid.
REQ-029 Without CHUNK_ADDER_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=16, CHUNK=4)
REQ-030 Stimulus a=0x00FF, b=0x0001, cin=0, sub=0, accepted in cycle T -> out_valid first high in cycle T+5, with sum=0x0100 and cout=0.
REQ-031 Stimulus a=0xFFFF, b=0x0001, cin=0, then a=0x1234, b=0x1111, cin=1 -> first result sum=0x0000, cout=1; second result sum=0x2346, cout=0.
REQ-032 Stimulus sub=1, a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0 (cin ignored); with CHUNK_ADDER_OVF_EN, ovf=0.
REQ-033 With CHUNK_ADDER_OVF_EN, a=0x7FFF, b=0x0001 add -> sum=0x8000, ovf=1.
REQ-034 With CHUNK_ADDER_OVF_EN, a=0x8000, b=0x0001 sub -> sum=0x7FFF, ovf=1.
REQ-035 Stimulus out_ready held 0 for 3 cycles after out_valid, with in_valid=1 throughout -> outputs stable, in_ready=0, no second accept until the cycle after out_ready=1.
REQ-036 Stimulus rst_n pulsed low mid-RUN, asynchronous to clk -> all outputs 0 immediately, no out_valid for the aborted operation, and a fresh operand accepted at the next edge after release.
